// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port-0 arbiter: FSM states, operation kind and
// the per-requester pending entry.
package sdram_arb_pkg;

    localparam int ARB_ADDR_W = 21;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_DQM_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } arb_op_t;

    typedef struct packed {
        arb_op_t                 op;
        logic [ARB_ADDR_W-1:0]   addr;
        logic [ARB_DATA_W-1:0]   data;
        logic [ARB_DQM_W-1:0]    byte_en;
    } pend_entry_t;

endpackage

// File: rtl/sdram_rr_picker.sv
// Round-robin selector: returns the first pending index strictly after
// last_grant, wrapping, so the most recent owner is considered last.
module sdram_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      grant,
    output logic               any_valid
);

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!any_valid && pend[(32'(last_grant) + k) % NUM_REQ]) begin
                any_valid = 1'b1;
                grant     = GW'((32'(last_grant) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the sdram controller's port 0 between NUM_REQ requesters, one
// transaction at a time, with a one-entry pending latch per requester.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = ARB_ADDR_W,
    parameter int DATA_WIDTH = ARB_DATA_W,
    parameter int DQM_WIDTH  = ARB_DQM_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init_complete,
    input  logic [NUM_REQ-1:0]            req_rd,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*DQM_WIDTH-1:0]  req_byte_en,
    output logic [NUM_REQ-1:0]            req_busy,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         req_q,
    output logic [ADDR_WIDTH-1:0]         p0_addr,
    output logic [DATA_WIDTH-1:0]         p0_data,
    output logic [DQM_WIDTH-1:0]          p0_byte_en,
    output logic                          p0_rd_req,
    output logic                          p0_wr_req,
    input  logic [DATA_WIDTH-1:0]         p0_q,
    input  logic                          p0_available,
    input  logic                          p0_ready
);

    localparam int GW = $clog2(NUM_REQ);

    arb_state_t              state_q, state_d;
    pend_entry_t             ent_q [NUM_REQ];
    pend_entry_t             ent_d [NUM_REQ];
    logic [NUM_REQ-1:0]      pend_q, pend_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [GW-1:0]           last_q, last_d;
    logic [GW-1:0]           cur_q, cur_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DQM_WIDTH-1:0]    be_q, be_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   req_q_q, req_q_d;
    logic [GW-1:0]           pick;
    logic                    any_pend;

    sdram_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_picker (
        .pend       (pend_q),
        .last_grant (last_q),
        .grant      (pick),
        .any_valid  (any_pend)
    );

    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        pend_d  = pend_q;
        done_d  = '0;
        last_d  = last_q;
        cur_d   = cur_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        req_q_d = req_q_q;

        // A set latch ignores new requests, so the owner's entry stays stable
        // for the whole transaction and can be read back at completion.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if ((req_rd[i] || req_wr[i]) && !pend_q[i]) begin
                pend_d[i]        = 1'b1;
                ent_d[i].op      = req_wr[i] ? OP_WR : OP_RD;
                ent_d[i].addr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                ent_d[i].data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                ent_d[i].byte_en = req_byte_en[i*DQM_WIDTH +: DQM_WIDTH];
            end
        end

        case (state_q)
            ARB_IDLE: begin
                if (init_complete && any_pend) begin
                    cur_d  = pick;
                    addr_d = ent_q[pick].addr;
                    data_d = ent_q[pick].data;
                    be_d   = ent_q[pick].byte_en;
                    if (p0_available) begin
                        rd_d    = (ent_q[pick].op == OP_RD);
                        wr_d    = (ent_q[pick].op == OP_WR);
                        state_d = ARB_WAIT;
                    end else begin
                        state_d = ARB_ISSUE;
                    end
                end
            end
            ARB_ISSUE: begin
                if (p0_available) begin
                    rd_d    = (ent_q[cur_q].op == OP_RD);
                    wr_d    = (ent_q[cur_q].op == OP_WR);
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (p0_ready) begin
                    done_d[cur_q] = 1'b1;
                    if (ent_q[cur_q].op == OP_RD) begin
                        req_q_d = p0_q;
                    end
                    pend_d[cur_q] = 1'b0;
                    last_d        = cur_q;
                    state_d       = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                ent_q[i] <= '0;
            end
            pend_q  <= '0;
            done_q  <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            cur_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            req_q_q <= '0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            req_q_q <= req_q_d;
        end
    end

    assign req_busy   = pend_q;
    assign req_done   = done_q;
    assign req_q      = req_q_q;
    assign p0_addr    = addr_q;
    assign p0_data    = data_q;
    assign p0_byte_en = be_q;
    assign p0_rd_req  = rd_q;
    assign p0_wr_req  = wr_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small port-0 responder that
// stores writes, answers reads and logs the issue order.
module tb_sdram_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 21;
    localparam int DW = 32;
    localparam int BW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             init_complete;
    logic [NR-1:0]    req_rd, req_wr;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR*BW-1:0] req_byte_en;
    logic [NR-1:0]    req_busy, req_done;
    logic [DW-1:0]    req_q;
    logic [AW-1:0]    p0_addr;
    logic [DW-1:0]    p0_data;
    logic [BW-1:0]    p0_byte_en;
    logic             p0_rd_req, p0_wr_req;
    logic [DW-1:0]    p0_q;
    logic             p0_available;
    logic             p0_ready;

    sdram_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DQM_WIDTH  (BW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init_complete (init_complete),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_byte_en   (req_byte_en),
        .req_busy      (req_busy),
        .req_done      (req_done),
        .req_q         (req_q),
        .p0_addr       (p0_addr),
        .p0_data       (p0_data),
        .p0_byte_en    (p0_byte_en),
        .p0_rd_req     (p0_rd_req),
        .p0_wr_req     (p0_wr_req),
        .p0_q          (p0_q),
        .p0_available  (p0_available),
        .p0_ready      (p0_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder state
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] issue_log [$];
    int            rd_strobes = 0, wr_strobes = 0, both_cnt = 0, done_multi = 0;
    int            done_cnt [NR];
    logic [DW-1:0] last_q = '0;
    bit            auto_resp = 1'b1;
    logic          man_ready = 1'b0;
    int            resp_cnt = 0;
    logic          rd_pending = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    initial begin
        p0_ready = 1'b0;
        p0_q     = '0;
        for (int i = 0; i < NR; i++) done_cnt[i] = 0;
        forever begin
            @(negedge clk);
            p0_ready = man_ready;
            if (reset) resp_cnt = 0;
            if (p0_rd_req && p0_wr_req) both_cnt++;
            if ($countones(req_done) > 1) done_multi++;
            for (int i = 0; i < NR; i++) if (req_done[i]) done_cnt[i]++;
            if (req_done != '0) last_q = req_q;
            if (p0_rd_req || p0_wr_req) begin
                issue_log.push_back(p0_addr);
                if (p0_wr_req) begin
                    wr_strobes++;
                    mem[p0_addr] = p0_data;
                end else begin
                    rd_strobes++;
                end
                rd_pending = p0_rd_req;
                rd_addr    = p0_addr;
                resp_cnt   = 2;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0 && auto_resp) begin
                    p0_ready = 1'b1;
                    if (rd_pending) p0_q = mem.exists(rd_addr) ? mem[rd_addr] : '0;
                    else            p0_q = 32'hDEAD_BEEF;
                end
            end
        end
    end

    function automatic int total_done();
        return done_cnt[0] + done_cnt[1];
    endfunction

    task automatic set_req(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_rd[i]                 = rd;
        req_wr[i]                 = wr;
        req_addr[i*AW +: AW]      = a;
        req_data[i*DW +: DW]      = d;
        req_byte_en[i*BW +: BW]   = be;
    endtask

    task automatic clear_req();
        req_rd = '0;
        req_wr = '0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (total_done() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 200), 1);
    endtask

    task automatic do_reset(input logic init_after);
        clear_req();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        init_complete = init_after;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int n;
        reset = 1'b1; init_complete = 1'b0; p0_available = 1'b0;
        req_rd = '0; req_wr = '0; req_addr = '0; req_data = '0; req_byte_en = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", req_busy, 0);
        check("rst_done", req_done, 0);
        check("rst_strobe", {p0_rd_req, p0_wr_req}, 0);
        check("rst_p0_bus", {p0_addr, p0_data, p0_byte_en}, 0);
        check("rst_req_q", req_q, 0);
        reset = 1'b0; init_complete = 1'b1; p0_available = 1'b1;
        @(negedge clk);

        // Write then read from requester 0
        set_req(0, 0, 1, 21'h002020, 32'h1234, 4'hf);
        @(negedge clk); clear_req();
        check("t1_busy", req_busy, 2'b01);
        check("t1_no_strobe_yet", {p0_rd_req, p0_wr_req}, 2'b00);
        @(negedge clk);
        check("t1_wr_strobe", {p0_rd_req, p0_wr_req}, 2'b01);
        check("t1_addr", p0_addr, 21'h002020);
        check("t1_data", p0_data, 32'h1234);
        check("t1_be", p0_byte_en, 4'hf);
        @(negedge clk);
        check("t1_strobe_one_cycle", {p0_rd_req, p0_wr_req}, 2'b00);
        wait_done(1, "t1_wr_done_timeout");
        set_req(0, 1, 0, 21'h002020, 32'h0, 4'hf);
        @(negedge clk); clear_req();
        wait_done(2, "t1_rd_done_timeout");
        check("t1_done0", done_cnt[0], 2);
        check("t1_req_q_at_done", last_q, 32'h1234);
        check("t1_req_q_hold", req_q, 32'h1234);
        check("t1_wr_strobes", wr_strobes, 1);
        check("t1_rd_strobes", rd_strobes, 1);
        check("t1_busy_clear", req_busy, 0);

        // Simultaneous writes after reset: 0 first, then 1
        do_reset(1'b1);
        issue_log.delete();
        base = total_done();
        set_req(0, 0, 1, 21'h002021, 32'h5678, 4'hf);
        set_req(1, 0, 1, 21'h002022, 32'h9ABC, 4'hf);
        @(negedge clk); clear_req();
        check("t2_busy_both", req_busy, 2'b11);
        wait_done(base + 2, "t2_pair_timeout");
        check("t2_log_size", issue_log.size(), 2);
        check("t2_first", issue_log[0], 21'h002021);
        check("t2_second", issue_log[1], 21'h002022);
        // Requester 0 alone makes it the last grant, so 1 wins the next tie
        set_req(0, 0, 1, 21'h002023, 32'h1111, 4'hf);
        @(negedge clk); clear_req();
        wait_done(base + 3, "t2_single_timeout");
        set_req(0, 0, 1, 21'h002024, 32'h2222, 4'hf);
        set_req(1, 0, 1, 21'h002025, 32'h3333, 4'hf);
        @(negedge clk); clear_req();
        wait_done(base + 5, "t2_rr_timeout");
        check("t2_rr_first", issue_log[3], 21'h002025);
        check("t2_rr_second", issue_log[4], 21'h002024);
        check("t2_req_q_after_writes", req_q, 0);

        // p0_available held low while requester 1 is pending
        p0_available = 1'b0;
        base = total_done();
        set_req(1, 0, 1, 21'h002030, 32'hAAAA, 4'h3);
        @(negedge clk); clear_req();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t3_no_strobe_%0d", k), {p0_rd_req, p0_wr_req}, 2'b00);
            check($sformatf("t3_addr_stable_%0d", k), p0_addr, 21'h002030);
        end
        check("t3_busy", req_busy, 2'b10);
        p0_available = 1'b1;
        @(negedge clk);
        check("t3_strobe", {p0_rd_req, p0_wr_req}, 2'b01);
        check("t3_be", p0_byte_en, 4'h3);
        @(negedge clk);
        check("t3_single_strobe", {p0_rd_req, p0_wr_req}, 2'b00);
        wait_done(base + 1, "t3_done_timeout");

        // Re-requests while busy are dropped
        base = total_done();
        n = rd_strobes;
        set_req(0, 1, 0, 21'h002020, 32'h0, 4'hf);
        @(negedge clk); clear_req();
        for (int k = 0; k < 2; k++) begin
            set_req(0, 1, 0, 21'h002021, 32'h0, 4'hf);
            @(negedge clk); clear_req();
            check($sformatf("t4_busy_%0d", k), req_busy[0], 1'b1);
        end
        wait_done(base + 1, "t4_done_timeout");
        repeat (10) @(negedge clk);
        check("t4_one_rd", rd_strobes - n, 1);
        check("t4_done_once", total_done() - base, 1);
        check("t4_busy_clear", req_busy, 0);
        check("t4_req_q", req_q, 32'h1234);

        // Init gating
        do_reset(1'b0);
        issue_log.delete();
        base = total_done();
        set_req(0, 1, 0, 21'h002021, 32'h0, 4'hf);
        set_req(1, 1, 0, 21'h002022, 32'h0, 4'hf);
        @(negedge clk); clear_req();
        repeat (8) @(negedge clk);
        check("t5_busy_held", req_busy, 2'b11);
        check("t5_no_issue", issue_log.size(), 0);
        init_complete = 1'b1;
        wait_done(base + 2, "t5_done_timeout");
        check("t5_first", issue_log[0], 21'h002021);
        check("t5_second", issue_log[1], 21'h002022);
        check("t5_req_q", req_q, 32'h9ABC);
        set_req(0, 0, 1, 21'h002026, 32'h7777, 4'hf);
        @(negedge clk); clear_req();
        wait_done(base + 3, "t5_wr_timeout");
        check("t5_req_q_kept_on_write", req_q, 32'h9ABC);

        // Reset while waiting for completion, then a late p0_ready
        auto_resp = 1'b0;
        set_req(1, 1, 0, 21'h002030, 32'h0, 4'hf);
        @(negedge clk); clear_req();
        n = 0;
        while (p0_rd_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_strobe_seen", (n < 20), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", req_busy, 0);
        check("t6_rst_strobe", {p0_rd_req, p0_wr_req}, 0);
        check("t6_rst_p0_bus", {p0_addr, p0_data, p0_byte_en}, 0);
        check("t6_rst_req_q", req_q, 0);
        reset = 1'b0;
        base = total_done();
        @(posedge clk); #1 man_ready = 1'b1;
        @(posedge clk); #1 man_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_late_done", total_done() - base, 0);
        check("t6_busy_idle", req_busy, 0);
        auto_resp = 1'b1;
        issue_log.delete();
        set_req(0, 0, 1, 21'h002027, 32'h4444, 4'hf);
        set_req(1, 0, 1, 21'h002028, 32'h5555, 4'hf);
        @(negedge clk); clear_req();
        wait_done(base + 2, "t6_after_reset_timeout");
        check("t6_first_after_reset", issue_log[0], 21'h002027);

        check("never_both_strobes", both_cnt, 0);
        check("never_multi_done", done_multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
